// File: rtl/sync_fifo_pf_if.sv
// sync_fifo_pf_if: handshake, data and status bundle for sync_fifo_pf.
interface sync_fifo_pf_if #(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 8
);
    logic              wr_en;
    logic [DWIDTH-1:0] din;
    logic              rd_en;
    logic [DWIDTH-1:0] dout;
    logic              err_clr;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [AWIDTH:0]   count;
    logic              overflow;
    logic              underflow;
    modport master (
        output wr_en, din, rd_en, err_clr,
        input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
    modport slave (
        input  wr_en, din, rd_en, err_clr,
        output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_pf.sv
// sync_fifo_pf: single-clock FIFO with count, almost flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through; default is a registered read.
module sync_fifo_pf #(
    parameter int AWIDTH   = 4,
    parameter int DWIDTH   = 8,
    parameter int AF_LEVEL = (1 << AWIDTH) - 2,
    parameter int AE_LEVEL = 2
) (
    input logic          clk,
    input logic          rst,
    sync_fifo_pf_if.slave bus
);
    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] AF_C    = (AWIDTH+1)'(AF_LEVEL);
    localparam logic [AWIDTH:0] AE_C    = (AWIDTH+1)'(AE_LEVEL);
    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AWIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AWIDTH:0]   count_q, count_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic              wr_acc, rd_acc;
    assign bus.full         = count_q == DEPTH_C;
    assign bus.empty        = count_q == '0;
    assign bus.almost_full  = count_q >= AF_C;
    assign bus.almost_empty = count_q <= AE_C;
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
    // A read frees the slot a full-FIFO write needs, so the write is accepted.
    always_comb begin
        rd_acc  = bus.rd_en && !bus.empty;
        wr_acc  = bus.wr_en && (!bus.full || bus.rd_en);
        wptr_d  = wptr_q + AWIDTH'(wr_acc);
        rptr_d  = rptr_q + AWIDTH'(rd_acc);
        count_d = count_q + (AWIDTH+1)'(wr_acc) - (AWIDTH+1)'(rd_acc);
        ovf_d   = (ovf_q && !bus.err_clr) || (bus.wr_en && !wr_acc);
        udf_d   = (udf_q && !bus.err_clr) || (bus.rd_en && bus.empty);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wptr_q] <= bus.din;
    end
`ifdef SYNC_FIFO_FWFT_EN
    assign bus.dout = mem_q[rptr_q];
`else
    logic [DWIDTH-1:0] dout_q, dout_d;
    assign dout_d   = rd_acc ? mem_q[rptr_q] : dout_q;
    assign bus.dout = dout_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dout_q <= '0;
        else     dout_q <= dout_d;
    end
`endif
endmodule

// File: tb/tb_sync_fifo_pf.sv
// tb_sync_fifo_pf: directed self-checking bench for sync_fifo_pf.
module tb_sync_fifo_pf;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] exp_q [$];
    logic [7:0] e;
    sync_fifo_pf_if #(.AWIDTH(4), .DWIDTH(8)) bus ();
    sync_fifo_pf #(.AWIDTH(4), .DWIDTH(8), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset;
        bus.wr_en = 0; bus.rd_en = 0; bus.err_clr = 0; bus.din = 0;
        step;
        step;
        total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        total++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin bad++; $display("FAIL reset_empty_full got=%b%b exp=10", bus.empty, bus.full); end
        total++; if (bus.almost_empty !== 1'b1 || bus.almost_full !== 1'b0) begin bad++; $display("FAIL reset_almost got=%b%b exp=10", bus.almost_empty, bus.almost_full); end
        total++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin bad++; $display("FAIL reset_err got=%b%b exp=00", bus.overflow, bus.underflow); end
`ifndef SYNC_FIFO_FWFT_EN
        total++; if (bus.dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", bus.dout); end
`endif
        rst = 0;
        step;
    endtask
    task automatic test_fill_drain;
        for (int i = 1; i <= 16; i++) begin
            bus.wr_en = 1; bus.din = 8'(i);
            step;
            total++; if (bus.count !== 5'(i)) begin bad++; $display("FAIL fill_count got=%0d exp=%0d", bus.count, i); end
            total++; if (bus.almost_full !== (i >= 14)) begin bad++; $display("FAIL fill_af at=%0d got=%b exp=%b", i, bus.almost_full, i >= 14); end
            total++; if (bus.almost_empty !== (i <= 2)) begin bad++; $display("FAIL fill_ae at=%0d got=%b exp=%b", i, bus.almost_empty, i <= 2); end
            total++; if (bus.full !== (i == 16)) begin bad++; $display("FAIL fill_full at=%0d got=%b exp=%b", i, bus.full, i == 16); end
        end
        bus.wr_en = 0;
        for (int i = 1; i <= 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
            total++; if (bus.dout !== 8'(i)) begin bad++; $display("FAIL drain_dout got=%h exp=%h", bus.dout, 8'(i)); end
`endif
            bus.rd_en = 1;
            step;
`ifndef SYNC_FIFO_FWFT_EN
            total++; if (bus.dout !== 8'(i)) begin bad++; $display("FAIL drain_dout got=%h exp=%h", bus.dout, 8'(i)); end
`endif
            total++; if (bus.count !== 5'(16 - i)) begin bad++; $display("FAIL drain_count got=%0d exp=%0d", bus.count, 16 - i); end
        end
        bus.rd_en = 0;
        total++; if (bus.empty !== 1'b1 || bus.underflow !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b%b exp=10", bus.empty, bus.underflow); end
    endtask
    task automatic test_overflow;
        for (int i = 1; i <= 16; i++) begin
            bus.wr_en = 1; bus.din = 8'(i);
            exp_q.push_back(8'(i));
            step;
        end
        bus.din = 8'hAA;
        step;
        bus.wr_en = 0;
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", bus.overflow); end
        total++; if (bus.count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", bus.count); end
        bus.err_clr = 1;
        step;
        bus.err_clr = 0;
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", bus.overflow); end
        bus.wr_en = 1; bus.err_clr = 1;
        step;
        bus.wr_en = 0; bus.err_clr = 0;
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%b exp=1", bus.overflow); end
        bus.err_clr = 1;
        step;
        bus.err_clr = 0;
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr2 got=%b exp=0", bus.overflow); end
    endtask
    task automatic test_full_rw;
        for (int k = 0; k < 40; k++) begin
            bus.wr_en = 1; bus.rd_en = 1; bus.din = 8'(8'h20 + k);
            exp_q.push_back(bus.din);
            e = exp_q.pop_front();
`ifdef SYNC_FIFO_FWFT_EN
            total++; if (bus.dout !== e) begin bad++; $display("FAIL full_rw_dout got=%h exp=%h", bus.dout, e); end
`endif
            step;
`ifndef SYNC_FIFO_FWFT_EN
            total++; if (bus.dout !== e) begin bad++; $display("FAIL full_rw_dout got=%h exp=%h", bus.dout, e); end
`endif
            total++; if (bus.count !== 5'd16) begin bad++; $display("FAIL full_rw_count got=%0d exp=16", bus.count); end
        end
        bus.wr_en = 0;
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL full_rw_ovf got=%b exp=0", bus.overflow); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
`ifdef SYNC_FIFO_FWFT_EN
            total++; if (bus.dout !== e) begin bad++; $display("FAIL full_rw_drain got=%h exp=%h", bus.dout, e); end
`endif
            step;
`ifndef SYNC_FIFO_FWFT_EN
            total++; if (bus.dout !== e) begin bad++; $display("FAIL full_rw_drain got=%h exp=%h", bus.dout, e); end
`endif
        end
        bus.rd_en = 0;
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL full_rw_empty got=%b exp=1", bus.empty); end
    endtask
    task automatic test_empty_rw;
        bus.wr_en = 1; bus.rd_en = 1; bus.din = 8'h55;
        step;
        bus.wr_en = 0;
        total++; if (bus.underflow !== 1'b1) begin bad++; $display("FAIL empty_rw_udf got=%b exp=1", bus.underflow); end
        total++; if (bus.count !== 5'd1) begin bad++; $display("FAIL empty_rw_count got=%0d exp=1", bus.count); end
`ifdef SYNC_FIFO_FWFT_EN
        total++; if (bus.dout !== 8'h55) begin bad++; $display("FAIL empty_rw_dout got=%h exp=55", bus.dout); end
`endif
        bus.err_clr = 1;
        step;
        bus.err_clr = 0;
`ifndef SYNC_FIFO_FWFT_EN
        total++; if (bus.dout !== 8'h55) begin bad++; $display("FAIL empty_rw_dout got=%h exp=55", bus.dout); end
`endif
        total++; if (bus.count !== 5'd0 || bus.underflow !== 1'b0) begin bad++; $display("FAIL empty_rw_after got=%0d/%b exp=0/0", bus.count, bus.underflow); end
        bus.rd_en = 0;
    endtask
    task automatic test_async_reset;
        for (int i = 0; i < 5; i++) begin
            bus.wr_en = 1; bus.din = 8'(8'h90 + i);
            step;
        end
        bus.wr_en = 0;
        total++; if (bus.count !== 5'd5) begin bad++; $display("FAIL arst_pre_count got=%0d exp=5", bus.count); end
        #3;
        rst = 1;
        #1;
        total++; if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin bad++; $display("FAIL arst_count got=%0d/%b exp=0/1", bus.count, bus.empty); end
`ifndef SYNC_FIFO_FWFT_EN
        total++; if (bus.dout !== 8'h00) begin bad++; $display("FAIL arst_dout got=%h exp=00", bus.dout); end
`endif
        rst = 0;
        bus.wr_en = 1; bus.din = 8'h3C;
        step;
        bus.wr_en = 0; bus.rd_en = 1;
        step;
        bus.rd_en = 0;
`ifndef SYNC_FIFO_FWFT_EN
        total++; if (bus.dout !== 8'h3C) begin bad++; $display("FAIL arst_post_dout got=%h exp=3c", bus.dout); end
`endif
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL arst_post_empty got=%b exp=1", bus.empty); end
    endtask
`ifdef SYNC_FIFO_FWFT_EN
    task automatic test_fwft;
        bus.wr_en = 1; bus.din = 8'h7E;
        step;
        total++; if (bus.empty !== 1'b0 || bus.dout !== 8'h7E) begin bad++; $display("FAIL fwft_first got=%b/%h exp=0/7e", bus.empty, bus.dout); end
        bus.din = 8'h7F;
        step;
        bus.wr_en = 0; bus.rd_en = 1;
        step;
        bus.rd_en = 0;
        total++; if (bus.dout !== 8'h7F || bus.count !== 5'd1) begin bad++; $display("FAIL fwft_pop got=%h/%0d exp=7f/1", bus.dout, bus.count); end
    endtask
`endif
    initial begin
        test_reset;
        test_fill_drain;
        test_overflow;
        test_full_rw;
        test_empty_rw;
        test_async_reset;
`ifdef SYNC_FIFO_FWFT_EN
        test_fwft;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sync_fifo_pf.md
# sync_fifo_pf

Parametrised single-clock FIFO with occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. It is the next-generation buffer for datapath stages that need back-pressure headroom, not just full/empty. Its read latency can be switched between registered output and first-word-fall-through.

## Interface
- AWIDTH, 4: address width; DEPTH = 2**AWIDTH entries (16).
- DWIDTH, 8: data word width.
- AF_LEVEL, DEPTH-2: almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  write request.
- din  in  DWIDTH  write data.
- rd_en  in  1  read/pop request.
- dout  out  DWIDTH  read data.
- err_clr  in  1  synchronous clear of overflow/underflow.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  AWIDTH+1  stored words, 0..DEPTH.
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a read was refused.

## Operation
- State: memory[DEPTH] (not reset), wptr/rptr (AWIDTH bits, wrap naturally DEPTH-1 -> 0), count register (AWIDTH+1 bits).
- Read accepted (rd_acc) = rd_en && !empty.
- Write accepted (wr_acc) = wr_en && (!full || rd_en). Writing while full with a concurrent read is accepted; count stays DEPTH.
- Writing while empty with a concurrent read: the write is accepted and the read is refused; count becomes 1.
- count' = count + wr_acc - rd_acc. Never exceeds DEPTH, never goes below 0.
- overflow sets on wr_en && !wr_acc. underflow sets on rd_en && empty.
- err_clr clears both flags. A set event in the same cycle as err_clr wins (the flag stays 1).
- full, empty, almost_full and almost_empty are decoded combinationally from the count register only.
- Reset values: wptr = rptr = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = underflow = 0, dout = 0 (standard mode).
- Reset mid-operation discards all contents immediately; memory contents are don't-care afterwards.

## Timing
- Write to flags: after an accepted write on edge N, count, empty and the other flags reflect it after edge N.
- Standard mode: after rd_acc on edge N, dout carries the head word after edge N and holds until the next rd_acc.
- Throughput: one write and one read per cycle, sustained, including at full and empty.

## Configuration
- SYNC_FIFO_FWFT_EN defined: first-word-fall-through mode.
  - dout = memory[rptr] combinationally; it is valid whenever empty = 0.
  - rd_acc pops the head, and dout shows the next word in the same cycle after the edge.
  - A write into an empty FIFO appears on dout one edge later, together with empty deasserting.
  - dout is undefined while empty = 1.
- SYNC_FIFO_FWFT_EN undefined: standard registered read with 1-cycle latency as above; no combinational path from memory to dout.

## Test plan
- Reset, then write 0x01..0x10 on 16 consecutive cycles -> count = 16, full = 1, almost_full = 1 from count 14; read 16 -> dout sequence 0x01..0x10, empty = 1.
- Full FIFO, wr_en = 1 with din = 0xAA and rd_en = 0 -> write dropped, overflow = 1, count = 16; err_clr pulse -> overflow = 0.
- Full FIFO, wr_en = rd_en = 1 for 40 cycles -> count stays 16, no overflow, every word read out in order across wrap-around.
- Empty FIFO, wr_en = rd_en = 1 with din = 0x55 -> underflow = 1, count = 1; next read returns 0x55.
- Write 5 words, assert rst asynchronously mid-cycle -> count = 0, empty = 1, dout = 0 without waiting for a clock edge; a subsequent write/read of 0x3C returns 0x3C.
- SYNC_FIFO_FWFT_EN build: write 0x7E into empty FIFO -> after one edge empty = 0 and dout = 0x7E before any rd_en; write 0x7F, pop once -> dout = 0x7F.
